stability_digit_ctrl: RTL

Sequential controller that tracks a 0..MAX_LEVEL stability score and produces the 4-bit digit value and DP control for the single 7-segment stability digit. It applies saturating increment, decrement and load updates from game logic and classifies the level into NORMAL, WARN and DEPLETED. It drives a blinking DP in WARN and a steady DP in DEPLETED, and pulses an event when stability reaches zero. Its outputs hex_value and dp_out connect directly to the stability digit's segment decoder (hex_value, dp_in; dp 1 = ON).

---
 rtl/stability_digit_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/stability_digit_ctrl.sv
// Stability score controller: saturating level register, NORMAL/WARN/DEPLETED classification,
// blinking/steady decimal-point request and a zero-entry pulse for the stability digit.
module stability_digit_ctrl #(
    parameter int unsigned INIT_LEVEL = 9,
    parameter int unsigned MAX_LEVEL  = 15,
    parameter int unsigned WARN_LEVEL = 3,
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    input  logic [3:0] amount,
    input  logic       set_valid,
    input  logic [3:0] set_value,
    input  logic       freeze,
    output logic [3:0] hex_value,
    output logic       dp_out,
    output logic       critical,
    output logic       zero_event
);

    localparam int unsigned CntW    = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [3:0]  MaxLvl  = 4'(MAX_LEVEL);
    localparam logic [3:0]  WarnLvl = 4'(WARN_LEVEL);
    localparam logic [3:0]  InitLvl = 4'(INIT_LEVEL);
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {StNormal, StWarn, StDepleted} state_e;

    function automatic state_e level_to_state(input logic [3:0] lvl);
        if (lvl == 4'd0) begin
            return StDepleted;
        end else if (lvl <= WarnLvl) begin
            return StWarn;
        end
        return StNormal;
    endfunction

    logic [3:0]      level_q, level_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            zero_q, zero_d;
    logic [4:0]      sum;

    always_comb begin
        sum     = {1'b0, level_q} + {1'b0, amount};
        level_d = level_q;
        if (set_valid) begin
            level_d = (set_value > MaxLvl) ? MaxLvl : set_value;
        end else if (freeze || (inc_pulse && dec_pulse)) begin
            level_d = level_q;
        end else if (inc_pulse) begin
            level_d = (sum > {1'b0, MaxLvl}) ? MaxLvl : sum[3:0];
        end else if (dec_pulse) begin
            level_d = (level_q >= amount) ? (level_q - amount) : 4'd0;
        end
        state_d = level_to_state(level_d);
        zero_d  = (level_d == 4'd0) && (level_q != 4'd0);
    end

    // Blink restarts only on entry into WARN; moves within WARN keep the running phase.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b1;
        if (state_d == StWarn && state_q == StWarn) begin
            if (cnt_q == CntLast) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= InitLvl;
            state_q <= level_to_state(InitLvl);
            cnt_q   <= '0;
            phase_q <= 1'b1;
            zero_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        dp_out = 1'b0;
        unique case (state_q)
            StNormal:   dp_out = 1'b0;
            StWarn:     dp_out = phase_q;
            StDepleted: dp_out = 1'b1;
            default:    dp_out = 1'b0;
        endcase
    end

    assign hex_value  = level_q;
    assign critical   = (state_q != StNormal);
    assign zero_event = zero_q;

endmodule
